// File: rtl/cm0ik_rom_wsbuf.sv
// cm0ik_rom_wsbuf
//   AHB-Lite read front-end for cm0ik_rom. Each ROM access is stretched by
//   WAITSTATES wait cycles so the ROM behaves like slow flash. A one-word
//   last-read buffer lets repeat reads of the same word complete with no
//   wait states. Writes get a two-cycle ERROR response.
module cm0ik_rom_wsbuf #(
    parameter int unsigned ADDRWIDTH  = 18,
    parameter int unsigned WAITSTATES = 2
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    input  logic        FLUSH,
    output logic        ROM_HSEL,
    output logic [31:0] ROM_HADDR,
    output logic [1:0]  ROM_HTRANS,
    output logic        ROM_HREADY,
    input  logic [31:0] ROM_HRDATA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIT,
        S_WAIT,
        S_RADDR,
        S_RDATA,
        S_ERR1,
        S_ERR2
    } state_t;

    // Wait counter preload; the WAITSTATES=0 case never enters S_WAIT.
    localparam logic [3:0] WS_LOAD = (WAITSTATES > 0) ? 4'(WAITSTATES - 1) : 4'd0;

    state_t                 state;
    logic [3:0]             cnt;
    logic                   buf_valid;
    logic [31:0]            buf_data;
    logic [ADDRWIDTH-1:0]   buf_tag;
    logic [31:2]            addr_q;
    logic [31:0]            hit_q;

    logic                   acc;
    logic                   hit;

    // Byte lane bits and HTRANS[0] carry no information for a word ROM.
    logic [2:0]             unused_bits;
    assign unused_bits = {HTRANS[0], HADDR[1:0]};

    assign acc = HSEL & HTRANS[1] & HREADY;
    assign hit = buf_valid & (buf_tag == HADDR[ADDRWIDTH+1:2]);

    // Transfer sequencing, buffer fill/flush and address-phase capture
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= S_IDLE;
            cnt       <= '0;
            buf_valid <= 1'b0;
            buf_data  <= '0;
            buf_tag   <= '0;
            addr_q    <= '0;
            hit_q     <= '0;
        end else begin
            if (state == S_RDATA) begin
                buf_data  <= ROM_HRDATA;
                buf_tag   <= addr_q[ADDRWIDTH+1:2];
                buf_valid <= 1'b1;
            end
            if (FLUSH) begin
                buf_valid <= 1'b0;
            end

            case (state)
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_RADDR;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RADDR: state <= S_RDATA;
                S_ERR1:  state <= S_ERR2;
                default: begin
                    if (acc) begin
                        addr_q <= HADDR[31:2];
                        if (HWRITE) begin
                            state <= S_ERR1;
                        end else if (hit) begin
                            // Snapshot the hit word: a fill completing on this
                            // same edge would otherwise replace it.
                            state <= S_HIT;
                            hit_q <= buf_data;
                        end else if (WAITSTATES > 0) begin
                            state <= S_WAIT;
                            cnt   <= WS_LOAD;
                        end else begin
                            state <= S_RADDR;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Bus and ROM-side outputs decoded from the current state
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = buf_data;
        ROM_HSEL  = 1'b0;
        ROM_HADDR = '0;
        case (state)
            S_WAIT:  HREADYOUT = 1'b0;
            S_RADDR: begin
                HREADYOUT = 1'b0;
                ROM_HSEL  = 1'b1;
                ROM_HADDR = {addr_q, 2'b00};
            end
            S_RDATA: HRDATA = ROM_HRDATA;
            S_HIT:   HRDATA = hit_q;
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2:  HRESP = 1'b1;
            default: ;
        endcase
        ROM_HTRANS = ROM_HSEL ? 2'b10 : 2'b00;
        ROM_HREADY = ROM_HSEL;
    end

endmodule

// File: tb/tb_cm0ik_rom_wsbuf.sv
// tb_cm0ik_rom_wsbuf
//   Three instances (WAITSTATES 0, 2, 15) exercised one at a time through a
//   shared AHB master. A transfer-level model predicts each response and
//   queues it; a negedge monitor pops and compares each data phase.
module tb_cm0ik_rom_wsbuf;

    localparam int NI = 3;

    typedef struct {
        logic        wr;
        logic [31:0] data;
        int unsigned lat;
        int unsigned rom;
        logic [31:0] raddr;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic        FLUSH = 1'b0;
    logic        hsel_g = 1'b0;
    int          cur = 0;

    logic [NI-1:0] hsel_v, hready_v, hresp_v, rhsel_v, rhready_v;
    logic [31:0]   hrdata_a  [NI];
    logic [31:0]   rhaddr_a  [NI];
    logic [1:0]    rhtrans_a [NI];

    logic        rdy, resp, rhsel, rhready;
    logic [31:0] hrdata, rhaddr;
    logic [1:0]  rhtrans;

    int vectors = 0;
    int miscompares = 0;

    exp_t sb[$];

    // ROM image: a fixed scramble of the word index
    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        logic [31:0] i;
        i = {14'h0, a[19:2]};
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic int unsigned ws_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 15;
    endfunction

    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned WSV = (g == 0) ? 0 : (g == 1) ? 2 : 15;
        logic [31:0] rom_q = '0;

        assign hsel_v[g] = hsel_g && (cur == g);

        // Behavioural ROM: data valid the cycle after select
        always @(posedge HCLK) if (rhsel_v[g]) rom_q <= rom_fn(rhaddr_a[g]);

        cm0ik_rom_wsbuf #(.ADDRWIDTH(18), .WAITSTATES(WSV)) u_dut (
            .HCLK      (HCLK),
            .HRESET    (HRESET),
            .HSEL      (hsel_v[g]),
            .HADDR     (HADDR),
            .HTRANS    (HTRANS),
            .HWRITE    (HWRITE),
            .HREADY    (hready_v[g]),
            .HRDATA    (hrdata_a[g]),
            .HREADYOUT (hready_v[g]),
            .HRESP     (hresp_v[g]),
            .FLUSH     (FLUSH),
            .ROM_HSEL  (rhsel_v[g]),
            .ROM_HADDR (rhaddr_a[g]),
            .ROM_HTRANS(rhtrans_a[g]),
            .ROM_HREADY(rhready_v[g]),
            .ROM_HRDATA(rom_q)
        );
    end

    assign rdy     = hready_v[cur];
    assign resp    = hresp_v[cur];
    assign hrdata  = hrdata_a[cur];
    assign rhsel   = rhsel_v[cur];
    assign rhaddr  = rhaddr_a[cur];
    assign rhtrans = rhtrans_a[cur];
    assign rhready = rhready_v[cur];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst=%0d t=%0t: got %h expected %h", nm, cur, $time, act, exp);
        end
    endtask

    // ---------------- reference model (transfer level) ----------------
    logic        m_valid, p_valid;
    logic [17:0] m_tag, p_tag;
    logic [31:0] m_data, p_data;

    task automatic model_reset();
        m_valid = 1'b0; m_tag = '0; m_data = '0;
        p_valid = 1'b0; p_tag = '0; p_data = '0;
    endtask

    task automatic apply_pend();
        if (p_valid) begin
            m_valid = 1'b1; m_tag = p_tag; m_data = p_data; p_valid = 1'b0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic wait_rdy(input string nm);
        int n = 0;
        @(negedge HCLK);
        while (!rdy && n < 50) begin
            @(negedge HCLK);
            n++;
        end
        if (!rdy) begin
            vectors++; miscompares++;
            $display("FAIL %s inst=%0d: HREADYOUT stuck low, got 0 expected 1", nm, cur);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic w);
        exp_t e;
        logic [17:0] idx;
        logic hit;
        idx = a[19:2];
        // Decision sees the buffer as it stands before any fill finishing now
        hit = m_valid && (m_tag == idx);
        e.raddr = '0; e.rom = 0; e.data = '0;
        if (w) begin
            e.wr = 1'b1; e.lat = 2;
        end else if (hit) begin
            e.wr = 1'b0; e.lat = 1; e.data = m_data;
        end else begin
            e.wr = 1'b0; e.lat = ws_of(cur) + 2; e.rom = 1;
            e.data = rom_fn(a); e.raddr = {a[31:2], 2'b00};
        end
        apply_pend();
        if (!w && !hit) begin
            p_valid = 1'b1; p_tag = idx; p_data = rom_fn(a);
        end
        sb.push_back(e);
        HADDR = a; HWRITE = w; HTRANS = 2'b10; hsel_g = 1'b1;
        wait_rdy("accept");
        @(posedge HCLK); #1;
        HTRANS = 2'b00; hsel_g = 1'b0; HWRITE = 1'b0;
    endtask

    // Idle until the current data phase ends, optionally flushing throughout
    task automatic idle(input logic f);
        FLUSH = f; HTRANS = 2'b00; hsel_g = 1'b0;
        wait_rdy("idle");
        @(posedge HCLK); #1;
        FLUSH = 1'b0;
        apply_pend();
        if (f) m_valid = 1'b0;
    endtask

    task automatic do_reset();
        HRESET = 1'b1; HTRANS = 2'b00; hsel_g = 1'b0; FLUSH = 1'b0;
        HWRITE = 1'b0; HADDR = '0;
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
        model_reset();
    endtask

    task automatic check_idle_outputs(input string nm);
        @(negedge HCLK);
        chk({nm, "_hreadyout"}, rdy, 1);
        chk({nm, "_hresp"}, resp, 0);
        chk({nm, "_hrdata"}, hrdata, 0);
        chk({nm, "_rom_hsel"}, rhsel, 0);
        chk({nm, "_rom_htrans"}, rhtrans, 0);
        chk({nm, "_rom_hready"}, rhready, 0);
        chk({nm, "_rom_haddr"}, rhaddr, 0);
        @(posedge HCLK); #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    exp_t        cur_e;
    bit          in_dp = 1'b0;
    int unsigned cyc, romcnt;

    always @(negedge HCLK) begin
        if (HRESET) begin
            in_dp = 1'b0;
        end else begin
            if (in_dp) begin
                cyc++;
                chk("hresp", resp, cur_e.wr);
                if (rhsel) begin
                    romcnt++;
                    chk("rom_haddr", rhaddr, cur_e.raddr);
                    chk("rom_htrans", rhtrans, 2'b10);
                    chk("rom_hready", rhready, 1);
                end
                if (rdy) begin
                    chk("latency", cyc, cur_e.lat);
                    chk("rom_accesses", romcnt, cur_e.rom);
                    if (!cur_e.wr) chk("hrdata", hrdata, cur_e.data);
                    in_dp = 1'b0;
                end else if (cyc > 40) begin
                    vectors++; miscompares++;
                    $display("FAIL dp_timeout inst=%0d: got %0d stall cycles expected %0d", cur, cyc, cur_e.lat);
                    in_dp = 1'b0;
                end
            end else begin
                chk("rom_hsel_idle", rhsel, 0);
            end
            if (hsel_g && HTRANS[1] && rdy) begin
                if (sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL scoreboard inst=%0d: got accept expected empty queue", cur);
                end else begin
                    cur_e = sb.pop_front();
                    in_dp = 1'b1; cyc = 0; romcnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        for (int i = 0; i < NI; i++) begin
            cur = i;
            do_reset();
            check_idle_outputs("reset");

            xfer(32'h100, 1'b0);                         // miss
            idle(1'b0);
            xfer(32'h100, 1'b0);                         // hit
            xfer(32'h200, 1'b1);                         // error
            xfer(32'h100, 1'b0);                         // still a hit
            idle(1'b1);
            xfer(32'h100, 1'b0);                         // miss after flush
            idle(1'b1);                                  // flush over the fill
            xfer(32'h100, 1'b0);                         // miss again
            idle(1'b1);
            xfer(32'h100, 1'b0);                         // back-to-back run
            xfer(32'h104, 1'b0);
            xfer(32'h100, 1'b0);
            xfer(32'h104, 1'b0);
            idle(1'b0);

            if (ws_of(cur) > 0) begin
                idle(1'b1);
                xfer(32'h300, 1'b0);                     // now in first WAIT cycle
                HRESET = 1'b1;
                @(posedge HCLK); #1;
                HRESET = 1'b0;
                model_reset();
                check_idle_outputs("rst_in_wait");
            end

            for (int k = 0; k < 80; k++) begin
                int unsigned r;
                logic [31:0] a;
                r = $urandom_range(0, 99);
                a = 32'h100 + 32'(4 * $urandom_range(0, 5));
                if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFF0_0000);
                a = a | 32'($urandom_range(0, 3));
                if (r < 70)      xfer(a, 1'b0);
                else if (r < 82) xfer(a, 1'b1);
                else if (r < 94) idle(1'b0);
                else             idle(1'b1);
            end

            idle(1'b0);
            idle(1'b0);
            begin
                int n = 0;
                while ((sb.size() != 0 || in_dp) && n < 100) begin
                    @(posedge HCLK);
                    n++;
                end
                if (sb.size() != 0 || in_dp) begin
                    vectors++; miscompares++;
                    $display("FAIL drain inst=%0d: got %0d pending expected 0", cur, sb.size());
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
